arb2_sel_ctrl: RTL

//   Two-requester round-robin arbiter that generates the select line for the

---
 rtl/arb2_pkg.sv | 14 +
 rtl/arb2_hold_cnt.sv | 40 ++++
 rtl/arb2_sel_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/arb2_pkg.sv
// Shared types for the two-requester mux-select arbiter.
// SIDE_A/SIDE_B double as the Mux2_1 .sel encoding and the "last granted" flag.
package arb2_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GNT_A = 2'd1,
        S_GNT_B = 2'd2
    } arb2_state_t;

    localparam logic SIDE_A = 1'b0;
    localparam logic SIDE_B = 1'b1;

endpackage

// File: rtl/arb2_hold_cnt.sv
// Saturating hold counter. Tracks how long the current grant has been kept.
// sat flags that the owner has used its full MAX_HOLD window.
module arb2_hold_cnt #(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic sat
);

    localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // NOTE: assigning a default before any branch keeps always_comb free of inferred latches.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat = (cnt_q == CNT_MAX);

endmodule

// File: rtl/arb2_sel_ctrl.sv
// Round-robin arbiter driving the Mux2_1 select line for requesters A and B.
// Every output is a flop; a hold limit forces a handover when both sides wait.
module arb2_sel_ctrl
    import arb2_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy
);

    arb2_state_t state_q, state_d;
    logic        last_q, last_d;
    logic        gnt_a_q, gnt_a_d;
    logic        gnt_b_q, gnt_b_d;
    logic        sel_q, sel_d;
    logic        busy_q, busy_d;
    logic        grant_entry;
    logic        hold_clr;
    logic        hold_en;
    logic        hold_sat;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_a && req_b) begin
                    state_d = (last_q == SIDE_A) ? S_GNT_B : S_GNT_A;
                end else if (req_a) begin
                    state_d = S_GNT_A;
                end else if (req_b) begin
                    state_d = S_GNT_B;
                end
            end
            S_GNT_A: begin
                if (!req_a) begin
                    state_d = req_b ? S_GNT_B : S_IDLE;
                end else if (req_b && hold_sat) begin
                    state_d = S_GNT_B;
                end
            end
            S_GNT_B: begin
                if (!req_b) begin
                    state_d = req_a ? S_GNT_A : S_IDLE;
                end else if (req_a && hold_sat) begin
                    state_d = S_GNT_A;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A grant entry is any move into a grant state, including a direct A<->B handover.
    always_comb begin
        grant_entry = (state_d != state_q) && (state_d != S_IDLE);
        hold_clr    = grant_entry;
        hold_en     = (state_d == state_q) && (state_q != S_IDLE);

        last_d = last_q;
        if (grant_entry) begin
            last_d = (state_d == S_GNT_B) ? SIDE_B : SIDE_A;
        end

        gnt_a_d = (state_d == S_GNT_A);
        gnt_b_d = (state_d == S_GNT_B);
        busy_d  = gnt_a_d | gnt_b_d;

        // sel parks on the last owner while idle so the mux output does not glitch.
        sel_d = sel_q;
        if (gnt_a_d) begin
            sel_d = SIDE_A;
        end else if (gnt_b_d) begin
            sel_d = SIDE_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            last_q  <= SIDE_B;
            gnt_a_q <= 1'b0;
            gnt_b_q <= 1'b0;
            sel_q   <= SIDE_A;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt_a_q <= gnt_a_d;
            gnt_b_q <= gnt_b_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
        end
    end

    arb2_hold_cnt #(
        .MAX_HOLD(MAX_HOLD)
    ) u_hold_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (hold_clr),
        .en   (hold_en),
        .sat  (hold_sat)
    );

    assign gnt_a = gnt_a_q;
    assign gnt_b = gnt_b_q;
    assign sel   = sel_q;
    assign busy  = busy_q;

endmodule
